// File: rtl/boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_pkg
// Brief    : Shared state encodings and word-packing constants for the
//            boot loader and its byte packer.
// Revision : 1.0 - initial release
// ============================================================================
package boot_loader_pkg;

    // Loader FSM states; encodings are fixed so other tools can decode them
    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam int c_bytes_per_word = 4;
    localparam int c_lane_width     = $clog2(c_bytes_per_word);

    // DONE and ERROR are sticky until reset and refuse further bytes
    function automatic logic is_terminal(input state_t s);
        return (s == S_DONE) || (s == S_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_byte_packer
// Brief    : Packs a byte stream into little-endian words. The first byte of
//            a word lands in bits [7:0]. word_valid pulses for one cycle the
//            cycle after the last byte of a word is taken.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader_byte_packer
    import boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_en,
    input  logic [7:0]            byte_data,
    output logic                  lane_last,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    logic [c_lane_width-1:0] r_lane;
    logic [DATA_WIDTH-9:0]   r_shift;
    logic                    r_word_valid;
    logic [DATA_WIDTH-1:0]   r_word;

    assign lane_last  = (r_lane == c_lane_width'(c_bytes_per_word - 1));
    assign word_valid = r_word_valid;
    assign word       = r_word;

    // Shift bytes in from the top so the oldest byte ends up in the low lane
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lane       <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (byte_en) begin
                r_lane  <= r_lane + 1'b1;
                r_shift <= {byte_data, r_shift[DATA_WIDTH-9:8]};
                if (lane_last) begin
                    r_word       <= {byte_data, r_shift};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader
// Brief    : Receives a program image as a byte stream (LEN lo, LEN hi,
//            4*LEN data bytes, XOR checksum), writes the packed words into
//            instruction/data memory and holds the CPU in reset until the
//            checksum verifies.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    // Largest image that fits between BASE_ADDR and the top of memory
    localparam int unsigned c_max_len = 32'((1 << ADDR_WIDTH) - BASE_ADDR);

    state_t                r_state;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_cpu_reset;
    logic                  r_load_done;
    logic                  r_load_error;
    logic [15:0]           r_words_loaded;
    logic [7:0]            r_xor;
    logic [15:0]           r_len;

    logic                  w_accept;
    logic                  w_pack_en;
    logic                  w_lane_last;
    logic                  w_word_valid;
    logic [DATA_WIDTH-1:0] w_word;
    logic [15:0]           w_len_full;
    logic                  w_len_too_big;
    logic                  w_last_word;

    assign w_accept      = in_valid & r_in_ready;
    assign w_pack_en     = w_accept && (r_state == S_DATA);
    assign w_len_full    = {in_data, r_len[7:0]};
    assign w_len_too_big = 32'(w_len_full) > c_max_len;
    assign w_last_word   = (r_words_loaded + 16'd1) == r_len;

    boot_loader_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_en    (w_pack_en),
        .byte_data  (in_data),
        .lane_last  (w_lane_last),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    assign in_ready     = r_in_ready;
    assign mem_we       = w_word_valid;
    assign mem_wdata    = w_word;
    assign mem_addr     = r_mem_addr;
    assign cpu_reset    = r_cpu_reset;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_words_loaded;

    // Load sequencer: header decode, word counting, checksum and verdict
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= S_HDR_LO;
            r_in_ready     <= 1'b0;
            r_mem_addr     <= ADDR_WIDTH'(BASE_ADDR);
            r_cpu_reset    <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_words_loaded <= '0;
            r_xor          <= '0;
            r_len          <= '0;
        end else begin
            r_in_ready <= !is_terminal(r_state);
            case (r_state)
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_xor      <= r_xor ^ in_data;
                        r_state    <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        r_xor <= r_xor ^ in_data;
                        if (w_len_too_big) begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_xor <= r_xor ^ in_data;
                        // The packer raises mem_we next cycle; address and
                        // count are registered alongside it
                        if (w_lane_last) begin
                            r_mem_addr     <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_words_loaded);
                            r_words_loaded <= r_words_loaded + 16'd1;
                            if (w_last_word) begin
                                r_state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_xor) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader
// Brief    : Self-checking bench for boot_loader. Streams images, predicts
//            memory writes into a scoreboard and checks the load verdict.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef logic [7:0] byte_q_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    wr_t sb[$];

    boot_loader #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .BASE_ADDR  (0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Every memory write must match the oldest predicted write
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_we_addr", {24'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check_eq("we_addr", {24'h0, mem_addr}, {24'h0, e.addr});
                check_eq("we_data", mem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit need_ready);
        int waits;
        waits = 0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            check_eq("rdy_in_gap", {31'h0, in_ready}, 32'h1);
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waits < 50) begin
            @(negedge clock);
            waits++;
        end
        if (waits >= 50) check_eq("accept_timeout", waits, 0);
        if (need_ready) check_eq("rdy_stall", waits, 0);
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check_eq("rst_in_ready",   {31'h0, in_ready},   32'h0);
        check_eq("rst_mem_we",     {31'h0, mem_we},     32'h0);
        check_eq("rst_mem_addr",   {24'h0, mem_addr},   32'h0);
        check_eq("rst_mem_wdata",  mem_wdata,           32'h0);
        check_eq("rst_cpu_reset",  {31'h0, cpu_reset},  32'h1);
        check_eq("rst_load_done",  {31'h0, load_done},  32'h0);
        check_eq("rst_load_error", {31'h0, load_error}, 32'h0);
        check_eq("rst_words",      {16'h0, words_loaded}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Stream an image, predicting writes and the verdict from the bytes.
    // stop_after > 0 sends only that many bytes and skips the verdict.
    task automatic run_stream(input byte_q_t s, input bit gappy, input int stop_after);
        int          len;
        int          widx;
        int          n;
        int          gap;
        logic [7:0]  acc;
        logic [31:0] w;
        bit          bad;
        bit          ovf;
        bit          err;
        len  = 0;
        widx = 0;
        acc  = 8'h00;
        w    = 32'h0;
        bad  = 1'b0;
        ovf  = 1'b0;
        n    = (stop_after > 0) ? stop_after : s.size();
        for (int k = 0; k < n; k++) begin
            gap = (gappy && (k % 2 == 1)) ? 2 : 0;
            if (k == 1) begin
                len = int'({s[1], s[0]});
                ovf = (len > 256);
            end
            if (k >= 2 && k < 2 + 4 * len) begin
                w = {s[k], w[31:8]};
                if ((k - 2) % 4 == 3) begin
                    sb.push_back({8'(widx), w});
                    widx++;
                end
            end
            if (k < s.size() - 1) acc = acc ^ s[k];
            else bad = (s[k] != acc);
            if (k == n - 1 && stop_after <= 0) begin
                check_eq("pre_load_done", {31'h0, load_done}, 32'h0);
                check_eq("pre_cpu_reset", {31'h0, cpu_reset}, 32'h1);
            end
            send_byte(s[k], gap, k > 0);
        end
        if (stop_after > 0) return;
        err = ovf || bad;
        @(negedge clock);
        in_valid = 1'b0;
        check_eq("load_done",  {31'h0, load_done},  {31'h0, !err});
        check_eq("load_error", {31'h0, load_error}, {31'h0, err});
        check_eq("cpu_reset",  {31'h0, cpu_reset},  {31'h0, err});
        check_eq("in_ready_end", {31'h0, in_ready}, 32'h0);
        check_eq("words_loaded", {16'h0, words_loaded}, widx);
        repeat (3) @(negedge clock);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    initial begin
        byte_q_t t1;
        byte_q_t t2;
        byte_q_t t3;
        byte_q_t t4;
        t1 = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        t2 = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
        t3 = '{8'h00, 8'h00, 8'h00};
        t4 = '{8'h01, 8'h01};

        repeat (2) @(negedge clock);
        do_reset();

        // Good image, back-to-back
        run_stream(t1, 1'b0, 0);

        // Bad checksum
        do_reset();
        run_stream(t2, 1'b0, 0);

        // Empty image
        do_reset();
        run_stream(t3, 1'b0, 0);

        // Length overflow, then bytes that must be ignored
        do_reset();
        run_stream(t4, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = 8'h55;
        end
        @(negedge clock);
        in_valid = 1'b0;
        check_eq("ovf_in_ready",   {31'h0, in_ready},   32'h0);
        check_eq("ovf_load_error", {31'h0, load_error}, 32'h1);
        check_eq("ovf_words",      {16'h0, words_loaded}, 32'h0);

        // Good image with valid pattern 1,0,0,1
        do_reset();
        run_stream(t1, 1'b1, 0);

        // Abort after 5 data bytes, then reload
        do_reset();
        run_stream(t1, 1'b0, 7);
        do_reset();
        check_eq("abort_sb_empty", sb.size(), 0);
        run_stream(t1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
